// File: rtl/fpga_key_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fpga_key_debounce
// Purpose  : Per-key synchronizer + debounce FSM with press/release/long-press
//            events funnelled into a single acknowledged event register.
// Revision : 1.0 - initial release
// ============================================================================
module fpga_key_debounce #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] fpga_key_n,
    output logic [NUM_KEYS-1:0] key_pressed,
    output logic                event_valid,
    output logic [2:0]          event_key,
    output logic [1:0]          event_type,
    input  logic                event_ack,
    output logic                event_overflow
);

    localparam int c_db_w   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int c_long_w = $clog2(LONG_CYCLES) + 1;

    localparam logic [c_db_w-1:0]   c_db_last   = c_db_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_db_w-1:0]   c_db_one    = c_db_w'(1);
    localparam logic [c_long_w-1:0] c_long_last = c_long_w'(LONG_CYCLES - 1);
    localparam logic [c_long_w-1:0] c_long_sat  = c_long_w'(LONG_CYCLES);
    localparam logic [c_long_w-1:0] c_long_one  = c_long_w'(1);

    localparam logic [1:0] c_st_released     = 2'd0;
    localparam logic [1:0] c_st_press_wait   = 2'd1;
    localparam logic [1:0] c_st_pressed      = 2'd2;
    localparam logic [1:0] c_st_release_wait = 2'd3;

    localparam logic [1:0] c_type_press   = 2'b01;
    localparam logic [1:0] c_type_release = 2'b10;
    localparam logic [1:0] c_type_long    = 2'b11;

    // Two-flop synchronizer, inverted so 1 = pressed from here on
    logic [NUM_KEYS-1:0] r_sync_meta;
    logic [NUM_KEYS-1:0] r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_meta <= '0;
            r_sync      <= '0;
        end else begin
            r_sync_meta <= ~fpga_key_n;
            r_sync      <= r_sync_meta;
        end
    end

    logic [NUM_KEYS-1:0] w_cand_press;
    logic [NUM_KEYS-1:0] w_cand_release;
    logic [NUM_KEYS-1:0] w_cand_long;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            logic [1:0]          r_state;
            logic [c_db_w-1:0]   r_stable_cnt;
            logic [c_long_w-1:0] r_hold_cnt;
            logic                r_pressed;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_state      <= c_st_released;
                    r_stable_cnt <= '0;
                    r_hold_cnt   <= '0;
                    r_pressed    <= 1'b0;
                end else begin
                    case (r_state)
                        c_st_released: begin
                            if (r_sync[gi]) begin
                                r_state      <= c_st_press_wait;
                                r_stable_cnt <= c_db_one;
                            end
                        end
                        c_st_press_wait: begin
                            if (!r_sync[gi]) begin
                                r_state      <= c_st_released;
                                r_stable_cnt <= '0;
                            end else if (r_stable_cnt == c_db_last) begin
                                r_state      <= c_st_pressed;
                                r_stable_cnt <= '0;
                                r_pressed    <= 1'b1;
                            end else begin
                                r_stable_cnt <= r_stable_cnt + c_db_one;
                            end
                        end
                        c_st_pressed: begin
                            // Saturation makes the long event fire once per press
                            if (r_hold_cnt != c_long_sat) begin
                                r_hold_cnt <= r_hold_cnt + c_long_one;
                            end
                            if (!r_sync[gi]) begin
                                r_state      <= c_st_release_wait;
                                r_stable_cnt <= c_db_one;
                            end
                        end
                        default: begin
                            if (r_sync[gi]) begin
                                r_state      <= c_st_pressed;
                                r_stable_cnt <= '0;
                            end else if (r_stable_cnt == c_db_last) begin
                                r_state      <= c_st_released;
                                r_stable_cnt <= '0;
                                r_hold_cnt   <= '0;
                                r_pressed    <= 1'b0;
                            end else begin
                                r_stable_cnt <= r_stable_cnt + c_db_one;
                            end
                        end
                    endcase
                end
            end

            assign w_cand_press[gi]   = (r_state == c_st_press_wait) && r_sync[gi]
                                        && (r_stable_cnt == c_db_last);
            assign w_cand_release[gi] = (r_state == c_st_release_wait) && !r_sync[gi]
                                        && (r_stable_cnt == c_db_last);
            assign w_cand_long[gi]    = (r_state == c_st_pressed) && (r_hold_cnt == c_long_last);
            assign key_pressed[gi]    = r_pressed;
        end
    endgenerate

    // Fixed priority: lowest key first, edge events ahead of long within a key
    logic       w_cand_any;
    logic       w_cand_multi;
    logic [2:0] w_win_key;
    logic [1:0] w_win_type;

    always_comb begin
        w_cand_any   = 1'b0;
        w_cand_multi = 1'b0;
        w_win_key    = 3'd0;
        w_win_type   = c_type_press;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (w_cand_press[i] || w_cand_release[i]) begin
                if (w_cand_any) begin
                    w_cand_multi = 1'b1;
                end else begin
                    w_cand_any = 1'b1;
                    w_win_key  = 3'(i);
                    w_win_type = w_cand_press[i] ? c_type_press : c_type_release;
                end
            end
            if (w_cand_long[i]) begin
                if (w_cand_any) begin
                    w_cand_multi = 1'b1;
                end else begin
                    w_cand_any = 1'b1;
                    w_win_key  = 3'(i);
                    w_win_type = c_type_long;
                end
            end
        end
    end

    logic       r_event_valid;
    logic [2:0] r_event_key;
    logic [1:0] r_event_type;
    logic       r_event_overflow;
    logic       w_accept;

    assign w_accept = !r_event_valid || event_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_event_valid    <= 1'b0;
            r_event_key      <= 3'd0;
            r_event_type     <= 2'b00;
            r_event_overflow <= 1'b0;
        end else begin
            if (w_cand_any && w_accept) begin
                r_event_valid <= 1'b1;
                r_event_key   <= w_win_key;
                r_event_type  <= w_win_type;
            end else if (event_ack) begin
                r_event_valid <= 1'b0;
            end
            if (w_cand_multi || (w_cand_any && !w_accept)) begin
                r_event_overflow <= 1'b1;
            end
        end
    end

    assign event_valid    = r_event_valid;
    assign event_key      = r_event_key;
    assign event_type     = r_event_type;
    assign event_overflow = r_event_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fpga_key_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fpga_key_debounce
// Purpose  : Directed self-checking bench for fpga_key_debounce (D=4, L=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpga_key_debounce;

    logic       clk;
    logic       reset_n;
    logic [3:0] fpga_key_n;
    logic [3:0] key_pressed;
    logic       event_valid;
    logic [2:0] event_key;
    logic [1:0] event_type;
    logic       event_ack;
    logic       event_overflow;

    int checks;
    int failures;

    // {key_pressed, event_valid, event_key, event_type, event_overflow}
    logic [10:0] obs;
    assign obs = {key_pressed, event_valid, event_key, event_type, event_overflow};

    fpga_key_debounce #(
        .NUM_KEYS        (4),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (10)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fpga_key_n     (fpga_key_n),
        .key_pressed    (key_pressed),
        .event_valid    (event_valid),
        .event_key      (event_key),
        .event_type     (event_type),
        .event_ack      (event_ack),
        .event_overflow (event_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        fpga_key_n = 4'hF;
        event_ack  = 1'b0;
        repeat (3) tick();
        checks++;
        if (obs !== 11'b0) begin
            failures++; $display("FAIL reset_state got=%b exp=%b", obs, 11'b0);
        end
        reset_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (obs !== 11'b0) begin
            failures++; $display("FAIL post_reset_idle got=%b exp=%b", obs, 11'b0);
        end
    endtask

    task automatic test_press();
        fpga_key_n = 4'b1110;
        repeat (5) tick();
        checks++;
        if (obs !== {4'b0000, 1'b0, 3'd0, 2'b00, 1'b0}) begin
            failures++; $display("FAIL press_edge5 got=%b exp=%b", obs, {4'b0000, 1'b0, 3'd0, 2'b00, 1'b0});
        end
        tick();
        checks++;
        if (obs !== {4'b0001, 1'b1, 3'd0, 2'b01, 1'b0}) begin
            failures++; $display("FAIL press_edge6 got=%b exp=%b", obs, {4'b0001, 1'b1, 3'd0, 2'b01, 1'b0});
        end
        event_ack = 1'b1; tick(); event_ack = 1'b0;
        checks++;
        if (obs !== {4'b0001, 1'b0, 3'd0, 2'b01, 1'b0}) begin
            failures++; $display("FAIL press_ack got=%b exp=%b", obs, {4'b0001, 1'b0, 3'd0, 2'b01, 1'b0});
        end
        fpga_key_n = 4'b1111;
        repeat (5) tick();
        checks++;
        if (obs !== {4'b0001, 1'b0, 3'd0, 2'b01, 1'b0}) begin
            failures++; $display("FAIL release_edge5 got=%b exp=%b", obs, {4'b0001, 1'b0, 3'd0, 2'b01, 1'b0});
        end
        tick();
        checks++;
        if (obs !== {4'b0000, 1'b1, 3'd0, 2'b10, 1'b0}) begin
            failures++; $display("FAIL release_edge6 got=%b exp=%b", obs, {4'b0000, 1'b1, 3'd0, 2'b10, 1'b0});
        end
        event_ack = 1'b1; tick(); event_ack = 1'b0;
        checks++;
        if (obs !== {4'b0000, 1'b0, 3'd0, 2'b10, 1'b0}) begin
            failures++; $display("FAIL release_ack got=%b exp=%b", obs, {4'b0000, 1'b0, 3'd0, 2'b10, 1'b0});
        end
    endtask

    task automatic test_glitch();
        fpga_key_n = 4'b1101;
        repeat (3) tick();
        fpga_key_n = 4'b1111;
        for (int n = 0; n < 10; n++) begin
            tick();
            checks++;
            if (obs !== {4'b0000, 1'b0, 3'd0, 2'b10, 1'b0}) begin
                failures++; $display("FAIL glitch_cycle%0d got=%b exp=%b", n, obs, {4'b0000, 1'b0, 3'd0, 2'b10, 1'b0});
            end
        end
    endtask

    task automatic test_long_press();
        fpga_key_n = 4'b1011;
        for (int n = 1; n <= 26; n++) begin
            event_ack = (n == 7 || n == 17);
            tick();
            if (n == 6) begin
                checks++;
                if (obs !== {4'b0100, 1'b1, 3'd2, 2'b01, 1'b0}) begin
                    failures++; $display("FAIL long_press_evt got=%b exp=%b", obs, {4'b0100, 1'b1, 3'd2, 2'b01, 1'b0});
                end
            end
            if (n >= 7 && n <= 15) begin
                checks++;
                if (obs !== {4'b0100, 1'b0, 3'd2, 2'b01, 1'b0}) begin
                    failures++; $display("FAIL long_wait_n%0d got=%b exp=%b", n, obs, {4'b0100, 1'b0, 3'd2, 2'b01, 1'b0});
                end
            end
            if (n == 16) begin
                checks++;
                if (obs !== {4'b0100, 1'b1, 3'd2, 2'b11, 1'b0}) begin
                    failures++; $display("FAIL long_evt got=%b exp=%b", obs, {4'b0100, 1'b1, 3'd2, 2'b11, 1'b0});
                end
            end
            if (n >= 17 && n <= 25) begin
                checks++;
                if (obs !== {4'b0100, 1'b0, 3'd2, 2'b11, 1'b0}) begin
                    failures++; $display("FAIL long_once_n%0d got=%b exp=%b", n, obs, {4'b0100, 1'b0, 3'd2, 2'b11, 1'b0});
                end
            end
            if (n == 26) begin
                checks++;
                if (obs !== {4'b0000, 1'b1, 3'd2, 2'b10, 1'b0}) begin
                    failures++; $display("FAIL long_release got=%b exp=%b", obs, {4'b0000, 1'b1, 3'd2, 2'b10, 1'b0});
                end
            end
            if (n == 20) fpga_key_n = 4'b1111;
        end
        event_ack = 1'b1; tick(); event_ack = 1'b0;
        checks++;
        if (obs !== {4'b0000, 1'b0, 3'd2, 2'b10, 1'b0}) begin
            failures++; $display("FAIL long_final got=%b exp=%b", obs, {4'b0000, 1'b0, 3'd2, 2'b10, 1'b0});
        end
    endtask

    task automatic test_drop_unacked();
        fpga_key_n = 4'b1110;
        repeat (6) tick();
        checks++;
        if (obs !== {4'b0001, 1'b1, 3'd0, 2'b01, 1'b0}) begin
            failures++; $display("FAIL drop_press got=%b exp=%b", obs, {4'b0001, 1'b1, 3'd0, 2'b01, 1'b0});
        end
        fpga_key_n = 4'b1111;
        repeat (5) tick();
        checks++;
        if (obs !== {4'b0001, 1'b1, 3'd0, 2'b01, 1'b0}) begin
            failures++; $display("FAIL drop_before got=%b exp=%b", obs, {4'b0001, 1'b1, 3'd0, 2'b01, 1'b0});
        end
        tick();
        checks++;
        if (obs !== {4'b0000, 1'b1, 3'd0, 2'b01, 1'b1}) begin
            failures++; $display("FAIL drop_overflow got=%b exp=%b", obs, {4'b0000, 1'b1, 3'd0, 2'b01, 1'b1});
        end
        event_ack = 1'b1; tick(); event_ack = 1'b0;
        checks++;
        if (obs !== {4'b0000, 1'b0, 3'd0, 2'b01, 1'b1}) begin
            failures++; $display("FAIL drop_ack got=%b exp=%b", obs, {4'b0000, 1'b0, 3'd0, 2'b01, 1'b1});
        end
    endtask

    task automatic test_reset_mid_hold();
        fpga_key_n = 4'b1011;
        repeat (6) tick();
        checks++;
        if (obs !== {4'b0100, 1'b1, 3'd2, 2'b01, 1'b1}) begin
            failures++; $display("FAIL rst_first_press got=%b exp=%b", obs, {4'b0100, 1'b1, 3'd2, 2'b01, 1'b1});
        end
        event_ack = 1'b1; tick(); event_ack = 1'b0;
        repeat (2) tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== 11'b0) begin
            failures++; $display("FAIL rst_async got=%b exp=%b", obs, 11'b0);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (5) tick();
        checks++;
        if (obs !== 11'b0) begin
            failures++; $display("FAIL rst_edge5 got=%b exp=%b", obs, 11'b0);
        end
        tick();
        checks++;
        if (obs !== {4'b0100, 1'b1, 3'd2, 2'b01, 1'b0}) begin
            failures++; $display("FAIL rst_repress got=%b exp=%b", obs, {4'b0100, 1'b1, 3'd2, 2'b01, 1'b0});
        end
        event_ack = 1'b1; tick(); event_ack = 1'b0;
        fpga_key_n = 4'b1111;
        repeat (6) tick();
        checks++;
        if (obs !== {4'b0000, 1'b1, 3'd2, 2'b10, 1'b0}) begin
            failures++; $display("FAIL rst_release got=%b exp=%b", obs, {4'b0000, 1'b1, 3'd2, 2'b10, 1'b0});
        end
        event_ack = 1'b1; tick(); event_ack = 1'b0;
    endtask

    task automatic test_simultaneous();
        fpga_key_n = 4'b0101;
        repeat (5) tick();
        checks++;
        if (obs !== {4'b0000, 1'b0, 3'd2, 2'b10, 1'b0}) begin
            failures++; $display("FAIL simul_edge5 got=%b exp=%b", obs, {4'b0000, 1'b0, 3'd2, 2'b10, 1'b0});
        end
        tick();
        checks++;
        if (obs !== {4'b1010, 1'b1, 3'd1, 2'b01, 1'b1}) begin
            failures++; $display("FAIL simul_press got=%b exp=%b", obs, {4'b1010, 1'b1, 3'd1, 2'b01, 1'b1});
        end
        event_ack = 1'b1; tick(); event_ack = 1'b0;
        checks++;
        if (obs !== {4'b1010, 1'b0, 3'd1, 2'b01, 1'b1}) begin
            failures++; $display("FAIL simul_ack got=%b exp=%b", obs, {4'b1010, 1'b0, 3'd1, 2'b01, 1'b1});
        end
        fpga_key_n = 4'b1111;
        repeat (6) tick();
        checks++;
        if (obs !== {4'b0000, 1'b1, 3'd1, 2'b10, 1'b1}) begin
            failures++; $display("FAIL simul_release got=%b exp=%b", obs, {4'b0000, 1'b1, 3'd1, 2'b10, 1'b1});
        end
        event_ack = 1'b1; tick(); event_ack = 1'b0;
        checks++;
        if (obs !== {4'b0000, 1'b0, 3'd1, 2'b10, 1'b1}) begin
            failures++; $display("FAIL simul_final got=%b exp=%b", obs, {4'b0000, 1'b0, 3'd1, 2'b10, 1'b1});
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_press();
        test_glitch();
        test_long_press();
        test_drop_unacked();
        test_reset_mid_hold();
        test_simultaneous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
